bp_cce_cfg_endpoint: RTL and testbench

//  Per-tile config-bus endpoint consuming uncached cfg commands (e_cce_mem_uc_wr / e_cce_mem_uc_rd, size 8B)

---
 rtl/bp_cce_cfg_endpoint_pkg.sv | 74 +++++++
 rtl/bp_cfg_reg_decode.sv | 36 +++
 rtl/bp_cce_cfg_endpoint.sv | 159 +++++++++++++++
 tb/tb_bp_cce_cfg_endpoint.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_cfg_endpoint_pkg.sv
// Shared types for the per-tile cfg endpoint: memory message layout, tile mode enums,
// cfg register map and endpoint FSM encodings. BP_CFG_ENDPOINT_ERR_EN maps the sticky error register.
package bp_cce_cfg_endpoint_pkg;

  localparam int paddr_width_gp    = 40;
  localparam int dword_width_gp    = 64;
  localparam int vaddr_width_gp    = 39;
  localparam int cfg_addr_width_gp = 16;
  localparam int payload_width_gp  = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1 = 3'd0,
    e_mem_size_2 = 3'd1,
    e_mem_size_4 = 3'd2,
    e_mem_size_8 = 3'd3
  } bp_mem_size_e;

  typedef struct packed {
    bp_cce_mem_cmd_type_e        msg_type;
    logic [paddr_width_gp-1:0]   addr;
    logic [payload_width_gp-1:0] payload;
    bp_mem_size_e                size;
  } bp_cce_mem_header_s;

  typedef struct packed {
    bp_cce_mem_header_s        header;
    logic [dword_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  // Register map within the low cfg_addr_width_gp address bits; the ucode base is window-aligned
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_reset_gp          = 16'h0001;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_freeze_gp         = 16'h0002;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_icache_mode_gp    = 16'h0003;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_dcache_mode_gp    = 16'h0004;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_cce_mode_gp       = 16'h0005;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_npc_gp            = 16'h0006;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_err_gp            = 16'h0007;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_mem_base_cce_ucode_gp = 16'h8000;

  localparam logic [1:0] e_ready    = 2'd0;
  localparam logic [1:0] e_ucode_rd = 2'd1;
  localparam logic [1:0] e_resp     = 2'd2;

  typedef struct packed {
    logic core_reset;
    logic freeze;
    logic icache_mode;
    logic dcache_mode;
    logic cce_mode;
    logic npc;
    logic err;
  } bp_cfg_reg_sel_s;

endpackage

// File: rtl/bp_cfg_reg_decode.sv
// Combinational cfg address decode: one-hot register select, ucode window hit/offset, unmapped flag.
// The error register decodes only when BP_CFG_ENDPOINT_ERR_EN is defined.
module bp_cfg_reg_decode
  import bp_cce_cfg_endpoint_pkg::*;
#(
  parameter int inst_ram_addr_width_p = 8
) (
  input  logic [cfg_addr_width_gp-1:0]     addr_i,
  output bp_cfg_reg_sel_s                  sel_o,
  output logic                             ucode_v_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic                             unmapped_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    sel_o        = '0;
    ucode_v_o    = (addr_i[cfg_addr_width_gp-1:inst_ram_addr_width_p]
                    == bp_cfg_mem_base_cce_ucode_gp[cfg_addr_width_gp-1:inst_ram_addr_width_p]);
    ucode_addr_o = addr_i[inst_ram_addr_width_p-1:0];
    case (addr_i)
      bp_cfg_reg_reset_gp:       sel_o.core_reset  = 1'b1;
      bp_cfg_reg_freeze_gp:      sel_o.freeze      = 1'b1;
      bp_cfg_reg_icache_mode_gp: sel_o.icache_mode = 1'b1;
      bp_cfg_reg_dcache_mode_gp: sel_o.dcache_mode = 1'b1;
      bp_cfg_reg_cce_mode_gp:    sel_o.cce_mode    = 1'b1;
      bp_cfg_reg_npc_gp:         sel_o.npc         = 1'b1;
`ifdef BP_CFG_ENDPOINT_ERR_EN
      bp_cfg_reg_err_gp:         sel_o.err         = 1'b1;
`endif
      default: ;
    endcase
    unmapped_o = ~ucode_v_o & ~(|sel_o);
  end

endmodule

// File: rtl/bp_cce_cfg_endpoint.sv
// Per-tile cfg endpoint: one uncached cfg command in flight, drives tile control regs and the CCE ucode port.
// Define BP_CFG_ENDPOINT_ERR_EN for a sticky unmapped-access error register and DEADBEEF unmapped reads.
module bp_cce_cfg_endpoint
  import bp_cce_cfg_endpoint_pkg::*;
#(
  parameter int inst_width_p          = 32,
  parameter int inst_ram_addr_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [cce_mem_msg_width_gp-1:0]  io_cmd_i,
  input  logic                             io_cmd_v_i,
  output logic                             io_cmd_ready_o,
  output logic [cce_mem_msg_width_gp-1:0]  io_resp_o,
  output logic                             io_resp_v_o,
  input  logic                             io_resp_yumi_i,
  output logic                             core_reset_o,
  output logic                             freeze_o,
  output bp_lce_mode_e                     icache_mode_o,
  output bp_lce_mode_e                     dcache_mode_o,
  output bp_cce_mode_e                     cce_mode_o,
  output logic                             npc_w_v_o,
  output logic [vaddr_width_gp-1:0]        npc_o,
  output logic                             ucode_v_o,
  output logic                             ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic [inst_width_p-1:0]          ucode_data_o,
  input  logic [inst_width_p-1:0]          ucode_data_i
);

  bp_cce_mem_msg_s                 cmd, resp;
  logic [1:0]                      state_q, state_d;
  bp_cce_mem_header_s              hdr_q;
  logic [dword_width_gp-1:0]       resp_data_q, resp_data_d, rd_data, unmapped_rd_data;
  logic                            core_reset_q, freeze_q, npc_w_v_q;
  bp_lce_mode_e                    icache_mode_q, dcache_mode_q;
  bp_cce_mode_e                    cce_mode_q;
  logic [vaddr_width_gp-1:0]       npc_q;
  bp_cfg_reg_sel_s                 dec_sel;
  logic                            dec_ucode_v, dec_unmapped;
  logic [inst_ram_addr_width_p-1:0] dec_ucode_addr;
  logic                            accept, is_wr, unused_bits;

  assign cmd    = io_cmd_i;
  assign is_wr  = (cmd.header.msg_type == e_cce_mem_uc_wr);
  assign accept = io_cmd_v_i & io_cmd_ready_o;

  bp_cfg_reg_decode #(
    .inst_ram_addr_width_p(inst_ram_addr_width_p)
  ) decode (
    .addr_i      (cmd.header.addr[cfg_addr_width_gp-1:0]),
    .sel_o       (dec_sel),
    .ucode_v_o   (dec_ucode_v),
    .ucode_addr_o(dec_ucode_addr),
    .unmapped_o  (dec_unmapped)
  );

`ifdef BP_CFG_ENDPOINT_ERR_EN
  logic err_q;

  assign unmapped_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
  assign unused_bits      = ^cmd.data[dword_width_gp-1:vaddr_width_gp];

  always_ff @(posedge clk_i) begin
    if (reset_i)                             err_q <= 1'b0;
    else if (accept & dec_unmapped)          err_q <= 1'b1;
    else if (accept & is_wr & dec_sel.err)   err_q <= 1'b0;
  end
`else
  assign unmapped_rd_data = '0;
  assign unused_bits      = ^{cmd.data[dword_width_gp-1:vaddr_width_gp], dec_sel.err};
`endif

  always_comb begin
    rd_data = '0;
    if (dec_sel.core_reset)  rd_data[0]                  = core_reset_q;
    if (dec_sel.freeze)      rd_data[0]                  = freeze_q;
    if (dec_sel.icache_mode) rd_data[1:0]                = icache_mode_q;
    if (dec_sel.dcache_mode) rd_data[1:0]                = dcache_mode_q;
    if (dec_sel.cce_mode)    rd_data[0]                  = cce_mode_q;
    if (dec_sel.npc)         rd_data[vaddr_width_gp-1:0] = npc_q;
`ifdef BP_CFG_ENDPOINT_ERR_EN
    if (dec_sel.err)         rd_data[0]                  = err_q;
`endif
    if (dec_unmapped)        rd_data                     = unmapped_rd_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_ready:    if (accept) state_d = (!is_wr && dec_ucode_v) ? e_ucode_rd : e_resp;
      e_ucode_rd: state_d = e_resp;
      e_resp:     if (io_resp_yumi_i) state_d = e_ready;
      default:    state_d = e_ready;
    endcase
  end

  // Ucode read data arrives the cycle after the strobe, i.e. while in e_ucode_rd
  always_comb begin
    resp_data_d = resp_data_q;
    if (state_q == e_ucode_rd) begin
      resp_data_d                   = '0;
      resp_data_d[inst_width_p-1:0] = ucode_data_i;
    end else if (accept) begin
      resp_data_d = is_wr ? '0 : rd_data;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_q       <= e_ready;
      core_reset_q  <= 1'b1;
      freeze_q      <= 1'b1;
      icache_mode_q <= e_lce_mode_uncached;
      dcache_mode_q <= e_lce_mode_uncached;
      cce_mode_q    <= e_cce_mode_uncached;
      npc_q         <= '0;
      npc_w_v_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      npc_w_v_q <= accept & is_wr & dec_sel.npc;
      if (accept & is_wr) begin
        if (dec_sel.core_reset)  core_reset_q  <= cmd.data[0];
        if (dec_sel.freeze)      freeze_q      <= cmd.data[0];
        if (dec_sel.icache_mode) icache_mode_q <= bp_lce_mode_e'(cmd.data[1:0]);
        if (dec_sel.dcache_mode) dcache_mode_q <= bp_lce_mode_e'(cmd.data[1:0]);
        if (dec_sel.cce_mode)    cce_mode_q    <= bp_cce_mode_e'(cmd.data[0]);
        if (dec_sel.npc)         npc_q         <= cmd.data[vaddr_width_gp-1:0];
      end
    end
  end

  // NOTE: response datapath regs are not reset; they are only observed while state_q says e_resp.
  always_ff @(posedge clk_i) begin
    if (accept) hdr_q <= cmd.header;
    resp_data_q <= resp_data_d;
  end

  assign resp.header    = hdr_q;
  assign resp.data      = resp_data_q;
  assign io_resp_o      = resp;
  assign io_resp_v_o    = (state_q == e_resp) & ~reset_i;
  assign io_cmd_ready_o = (state_q == e_ready) & ~reset_i;

  assign core_reset_o  = core_reset_q;
  assign freeze_o      = freeze_q;
  assign icache_mode_o = icache_mode_q;
  assign dcache_mode_o = dcache_mode_q;
  assign cce_mode_o    = cce_mode_q;
  assign npc_w_v_o     = npc_w_v_q;
  assign npc_o         = npc_q;

  assign ucode_v_o    = accept & dec_ucode_v;
  assign ucode_w_o    = is_wr;
  assign ucode_addr_o = dec_ucode_addr;
  assign ucode_data_o = cmd.data[inst_width_p-1:0];

endmodule

// File: tb/tb_bp_cce_cfg_endpoint.sv
// Scoreboard bench for bp_cce_cfg_endpoint: expected responses queued at issue, compared on io_resp.
// Define BP_CFG_ENDPOINT_ERR_EN consistently with the RTL build to exercise the error register.
module tb_bp_cce_cfg_endpoint;
  import bp_cce_cfg_endpoint_pkg::*;

  localparam int iw = 32;
  localparam int aw = 8;
`ifdef BP_CFG_ENDPOINT_ERR_EN
  localparam logic [63:0] unmapped_exp = 64'hDEAD_BEEF_DEAD_BEEF;
`else
  localparam logic [63:0] unmapped_exp = 64'h0;
`endif
  localparam logic [15:0] ubase = bp_cfg_mem_base_cce_ucode_gp;

  logic                            clk_i = 1'b0;
  logic                            reset_i;
  logic [cce_mem_msg_width_gp-1:0] io_cmd_i, io_resp_o;
  logic                            io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
  logic                            core_reset_o, freeze_o, npc_w_v_o;
  bp_lce_mode_e                    icache_mode_o, dcache_mode_o;
  bp_cce_mode_e                    cce_mode_o;
  logic [vaddr_width_gp-1:0]       npc_o;
  logic                            ucode_v_o, ucode_w_o;
  logic [aw-1:0]                   ucode_addr_o;
  logic [iw-1:0]                   ucode_data_o, ucode_data_i;

  bp_cce_cfg_endpoint #(.inst_width_p(iw), .inst_ram_addr_width_p(aw)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .core_reset_o(core_reset_o), .freeze_o(freeze_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o),
    .npc_w_v_o(npc_w_v_o), .npc_o(npc_o),
    .ucode_v_o(ucode_v_o), .ucode_w_o(ucode_w_o), .ucode_addr_o(ucode_addr_o),
    .ucode_data_o(ucode_data_o), .ucode_data_i(ucode_data_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int npc_pulses = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (npc_w_v_o) npc_pulses <= npc_pulses + 1;
  end

  // Ucode RAM model: one-cycle read latency
  logic [iw-1:0] uram [256];
  always @(posedge clk_i) begin
    if (ucode_v_o) begin
      if (ucode_w_o) uram[ucode_addr_o] <= ucode_data_o;
      else           ucode_data_i       <= uram[ucode_addr_o];
    end
  end

  bp_cce_mem_msg_s sb_q[$];
  int              lat_q[$];
  int              acc_cyc;
  logic            acc_uv, acc_uw;
  logic [aw-1:0]   acc_ua;
  logic [iw-1:0]   acc_ud;
  bp_cce_mem_msg_s resp_s;
  assign resp_s = io_resp_o;

  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e mt, input logic [15:0] a,
                                         input logic [63:0] d);
    bp_cce_mem_msg_s m;
    m.header.msg_type = mt;
    m.header.addr     = {24'h00_0012, a};
    m.header.payload  = a ^ 16'h5A5A;
    m.header.size     = e_mem_size_8;
    m.data            = d;
    return m;
  endfunction

  // Issue one command (called at a negedge); the expected response goes on the scoreboard
  task automatic send(input bp_cce_mem_cmd_type_e mt, input logic [15:0] a, input logic [63:0] d,
                      input logic [63:0] exp_d, input int exp_lat);
    int n = 0;
    io_cmd_i   = mk(mt, a, d);
    io_cmd_v_i = 1'b1;
    while (io_cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout addr=%h ready never rose", a);
      io_cmd_v_i = 1'b0;
      return;
    end
    sb_q.push_back(mk(mt, a, exp_d));
    lat_q.push_back(exp_lat);
    #1;
    acc_uv  = ucode_v_o;
    acc_uw  = ucode_w_o;
    acc_ua  = ucode_addr_o;
    acc_ud  = ucode_data_o;
    acc_cyc = cyc;
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
  endtask

  task automatic drain_resp(input bit chk_lat);
    int n = 0;
    int el;
    bp_cce_mem_msg_s exp_m;
    while (io_resp_v_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL resp_timeout got no io_resp_v_o, required one");
      if (sb_q.size() > 0) begin
        void'(sb_q.pop_front());
        void'(lat_q.pop_front());
      end
      return;
    end
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL resp_unexpected got %h, required no response", io_resp_o);
    end else begin
      exp_m = sb_q.pop_front();
      el    = lat_q.pop_front();
      if (resp_s !== exp_m) begin
        fails++;
        $display("FAIL resp_msg got %h required %h", resp_s, exp_m);
      end
      if (chk_lat) begin
        tests++;
        if (cyc - acc_cyc != el) begin
          fails++;
          $display("FAIL resp_latency got %0d required %0d", cyc - acc_cyc, el);
        end
      end
    end
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; io_cmd_v_i = 1'b0; io_cmd_i = '0; io_resp_yumi_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if (io_cmd_ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_ready got %b required 0", io_cmd_ready_o);
    end
    tests++;
    if ({core_reset_o, freeze_o} !== 2'b11) begin
      fails++; $display("FAIL reset_ctl got %b required 11", {core_reset_o, freeze_o});
    end
    tests++;
    if (icache_mode_o !== e_lce_mode_uncached || dcache_mode_o !== e_lce_mode_uncached
        || cce_mode_o !== e_cce_mode_uncached) begin
      fails++; $display("FAIL reset_modes got %0d/%0d/%0d required 0/0/0",
                        icache_mode_o, dcache_mode_o, cce_mode_o);
    end
    tests++;
    if (npc_o !== '0 || npc_w_v_o !== 1'b0 || ucode_v_o !== 1'b0 || io_resp_v_o !== 1'b0) begin
      fails++; $display("FAIL reset_misc got npc=%h w=%b uv=%b rv=%b required all 0",
                        npc_o, npc_w_v_o, ucode_v_o, io_resp_v_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (io_cmd_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset got %b required 1", io_cmd_ready_o);
    end
  endtask

  task automatic test_freeze();
    send(e_cce_mem_uc_wr, bp_cfg_reg_freeze_gp, 64'h0, 64'h0, 1);
    tests++;
    if (freeze_o !== 1'b0) begin
      fails++; $display("FAIL freeze_write got %b required 0", freeze_o);
    end
    drain_resp(1'b1);
  endtask

  task automatic test_npc();
    int p0 = npc_pulses;
    send(e_cce_mem_uc_wr, bp_cfg_reg_npc_gp, 64'h8000_0000, 64'h0, 1);
    tests++;
    if (npc_w_v_o !== 1'b1 || npc_o !== 39'h00_8000_0000) begin
      fails++; $display("FAIL npc_write got w=%b npc=%h required 1/0080000000", npc_w_v_o, npc_o);
    end
    drain_resp(1'b1);
    tests++;
    if (npc_w_v_o !== 1'b0 || npc_pulses - p0 != 1) begin
      fails++; $display("FAIL npc_pulse got w=%b pulses=%0d required 0/1", npc_w_v_o, npc_pulses - p0);
    end
    send(e_cce_mem_uc_rd, bp_cfg_reg_npc_gp, 64'h0, 64'h8000_0000, 1);
    drain_resp(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4] = '{bp_cfg_reg_reset_gp, bp_cfg_reg_icache_mode_gp,
                               bp_cfg_reg_dcache_mode_gp, bp_cfg_reg_cce_mode_gp};
    logic [63:0] vals  [4] = '{64'h0, 64'h1, 64'h2, 64'h1};
    for (int i = 0; i < 4; i++) begin
      send(e_cce_mem_uc_wr, addrs[i], vals[i], 64'h0, 1);
      drain_resp(1'b1);
    end
    tests++;
    if (core_reset_o !== 1'b0 || icache_mode_o !== e_lce_mode_normal
        || dcache_mode_o !== e_lce_mode_nonspec || cce_mode_o !== e_cce_mode_normal) begin
      fails++; $display("FAIL mode_regs got %b/%0d/%0d/%0d required 0/1/2/1",
                        core_reset_o, icache_mode_o, dcache_mode_o, cce_mode_o);
    end
    for (int i = 0; i < 4; i++) begin
      send(e_cce_mem_uc_rd, addrs[i], 64'h0, vals[i], 1);
      drain_resp(1'b1);
    end
  endtask

  task automatic test_ucode();
    send(e_cce_mem_uc_wr, ubase + 16'd5, 64'hFFFF_0000_0000_1234, 64'h0, 1);
    tests++;
    if (acc_uv !== 1'b1 || acc_uw !== 1'b1 || acc_ua !== 8'd5 || acc_ud !== 32'h1234) begin
      fails++; $display("FAIL ucode_wr_strobe got v=%b w=%b a=%h d=%h required 1/1/05/00001234",
                        acc_uv, acc_uw, acc_ua, acc_ud);
    end
    drain_resp(1'b1);
    send(e_cce_mem_uc_rd, ubase + 16'd5, 64'h0, 64'h1234, 2);
    tests++;
    if (acc_uv !== 1'b1 || acc_uw !== 1'b0 || acc_ua !== 8'd5) begin
      fails++; $display("FAIL ucode_rd_strobe got v=%b w=%b a=%h required 1/0/05", acc_uv, acc_uw, acc_ua);
    end
    drain_resp(1'b1);
    send(e_cce_mem_uc_wr, ubase + 16'd255, 64'hCAFE_F00D, 64'h0, 1);
    tests++;
    if (acc_uv !== 1'b1 || acc_ua !== 8'hFF) begin
      fails++; $display("FAIL ucode_top_addr got v=%b a=%h required 1/ff", acc_uv, acc_ua);
    end
    drain_resp(1'b1);
    send(e_cce_mem_uc_rd, ubase + 16'd255, 64'h0, 64'hCAFE_F00D, 2);
    drain_resp(1'b1);
  endtask

  task automatic test_back_pressure();
    logic [cce_mem_msg_width_gp-1:0] snap;
    bit stable = 1'b1;
    send(e_cce_mem_uc_rd, bp_cfg_reg_icache_mode_gp, 64'h0, 64'h1, 1);
    tests++;
    if (io_resp_v_o !== 1'b1) begin
      fails++; $display("FAIL bp_resp_v got %b required 1", io_resp_v_o);
    end
    snap       = io_resp_o;
    io_cmd_i   = mk(e_cce_mem_uc_wr, bp_cfg_reg_freeze_gp, 64'h1);
    io_cmd_v_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (io_resp_v_o !== 1'b1 || io_resp_o !== snap || io_cmd_ready_o !== 1'b0) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      fails++; $display("FAIL bp_hold got unstable resp or ready, required stable with ready=0");
    end
    tests++;
    if (freeze_o !== 1'b0) begin
      fails++; $display("FAIL bp_no_accept got freeze=%b required 0", freeze_o);
    end
    drain_resp(1'b0);
    tests++;
    if (io_cmd_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_after_yumi got %b required 1", io_cmd_ready_o);
    end
    send(e_cce_mem_uc_wr, bp_cfg_reg_freeze_gp, 64'h1, 64'h0, 1);
    tests++;
    if (freeze_o !== 1'b1) begin
      fails++; $display("FAIL bp_second_cmd got freeze=%b required 1", freeze_o);
    end
    drain_resp(1'b1);
  endtask

  task automatic test_unmapped();
    send(e_cce_mem_uc_rd, 16'h0100, 64'h0, unmapped_exp, 1);
    drain_resp(1'b1);
    send(e_cce_mem_uc_rd, ubase + 16'd256, 64'h0, unmapped_exp, 1);
    drain_resp(1'b1);
    send(e_cce_mem_uc_wr, 16'h0102, 64'h0, 64'h0, 1);
    tests++;
    if (freeze_o !== 1'b1 || core_reset_o !== 1'b0 || ucode_v_o !== 1'b0) begin
      fails++; $display("FAIL unmapped_wr_side_effect got f=%b r=%b uv=%b required 1/0/0",
                        freeze_o, core_reset_o, ucode_v_o);
    end
    drain_resp(1'b1);
`ifdef BP_CFG_ENDPOINT_ERR_EN
    send(e_cce_mem_uc_rd, bp_cfg_reg_err_gp, 64'h0, 64'h1, 1);
    drain_resp(1'b1);
    send(e_cce_mem_uc_wr, bp_cfg_reg_err_gp, 64'h5, 64'h0, 1);
    drain_resp(1'b1);
    send(e_cce_mem_uc_rd, bp_cfg_reg_err_gp, 64'h0, 64'h0, 1);
    drain_resp(1'b1);
`else
    send(e_cce_mem_uc_rd, bp_cfg_reg_err_gp, 64'h0, 64'h0, 1);
    drain_resp(1'b1);
`endif
  endtask

  task automatic test_reset_mid_read();
    bit quiet = 1'b1;
    send(e_cce_mem_uc_wr, bp_cfg_reg_freeze_gp, 64'h0, 64'h0, 1);
    drain_resp(1'b1);
    send(e_cce_mem_uc_rd, ubase + 16'd5, 64'h0, 64'h1234, 2);
    reset_i = 1'b1;
    void'(sb_q.pop_back());
    void'(lat_q.pop_back());
    repeat (3) begin
      @(negedge clk_i);
      if (io_resp_v_o !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if ({core_reset_o, freeze_o} !== 2'b11 || npc_o !== '0 || icache_mode_o !== e_lce_mode_uncached
        || dcache_mode_o !== e_lce_mode_uncached || cce_mode_o !== e_cce_mode_uncached) begin
      fails++; $display("FAIL midreset_regs got r=%b f=%b npc=%h modes=%0d/%0d/%0d required 1/1/0/0/0/0",
                        core_reset_o, freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o);
    end
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (io_resp_v_o !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet || io_cmd_ready_o !== 1'b1) begin
      fails++; $display("FAIL midreset_resp got resp_v seen=%b ready=%b required 0/1", !quiet, io_cmd_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_npc();
    test_back_to_back();
    test_ucode();
    test_back_pressure();
    test_unmapped();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
